// File: rtl/iter_divider.sv
// Radix-2 restoring divider answering the EX-stage divide handshake.
// Returns {remainder, quotient} for HI/LO; one WIDTH-step division at a time.
module iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DZERO,
        BUSY,
        DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic             w_unused;

    assign w_a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Two guard bits: {rem,msb} can reach 2*|divisor|-1, so the sign sits above WIDTH+1 bits.
    assign w_trial   = {1'b0, r_rem, r_dvd[WIDTH-1]} - {2'b00, r_dsr};
    assign w_ge      = ~w_trial[WIDTH+1];
    assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};
    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_unused  = w_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= DZERO;
                        end else begin
                            r_dvd   <= w_a_abs;
                            r_dsr   <= w_b_abs;
                            r_rem   <= '0;
                            r_neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            r_neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end
                    end
                end
                DZERO: begin
                    result_o <= '0;
                    r_state  <= annul_i ? IDLE : DONE;
                end
                BUSY: begin
                    if (annul_i) begin
                        result_o <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_quo_nxt;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            result_o <= {w_rem_fix, w_quo_fix};
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // ready_o rises one cycle after entry, so a start already low still sees a 1-cycle pulse.
                    if (!ready_o) begin
                        ready_o <= 1'b1;
                    end else if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: driver pushes hand-computed results,
// a monitor pops and compares on each rising ready_o.
module tb_iter_divider;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int             n_vec  = 0;
    int             n_miss = 0;
    logic [2*W-1:0] exp_q[$];
    logic           prev_rdy = 1'b0;

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per rising edge of ready_o.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1 && prev_rdy !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_ready: got result %h expected no ready", result_o);
                end else begin
                    check("result", result_o, exp_q.pop_front());
                end
            end
            prev_rdy = ready_o;
        end
    end

    task automatic run_div(input string name, input bit s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] exp,
                           input int exp_lat, input bit hold, input int pre_annul);
        int lat;
        bit got;
        exp_q.push_back(exp);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = (pre_annul > 0);
        repeat (pre_annul) @(negedge clk);
        annul_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
        if (!hold) start_i = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 100 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            got = (ready_o === 1'b1);
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no ready in %0d cycles expected ready at %0d", name, lat, exp_lat);
            void'(exp_q.pop_back());
            start_i = 1'b0;
        end else begin
            check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        end
        if (hold) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(posedge clk);
        #1;
        check({name, "_ready_drop"}, 64'(ready_o), 64'd0);
        check({name, "_result_clear"}, result_o, 64'd0);
        @(negedge clk);
    endtask

    task automatic abort_div(input string name, input bit use_rst, input logic [W-1:0] b,
                             input int busy_cycles);
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (busy_cycles) @(posedge clk);
        @(negedge clk);
        opdata1_i = $urandom;
        if (use_rst) rst = 1'b1;
        else annul_i = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_ready"}, 64'(ready_o), 64'd0);
        check({name, "_result"}, result_o, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check({name, "_quiet"}, 64'(ready_o), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 1'b1, 0);
        run_div("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33, 1'b1, 0);
        run_div("div_7_m2",      1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 1'b1, 0);
        run_div("div_m7_m2",     1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 33, 1'b0, 0);
        run_div("divu_fff9_2",   1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 33, 1'b1, 0);
        run_div("div_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 1'b1, 0);
        run_div("div_min_1",     1'b1, 32'h80000000,   32'h00000001,   64'h00000000_80000000, 33, 1'b0, 0);
        run_div("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 33, 1'b1, 0);
        run_div("divu_3_10",     1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 33, 1'b1, 2);
        run_div("divu_hex",      1'b0, 32'h12345678,   32'h00000100,   64'h00000078_00123456, 33, 1'b0, 0);
        run_div("div_0_5",       1'b1, 32'd0,          32'd5,          64'h00000000_00000000, 33, 1'b1, 0);
        run_div("divu_5_0",      1'b0, 32'd5,          32'd0,          64'h00000000_00000000, 2,  1'b1, 0);
        run_div("div_m5_0",      1'b1, 32'hFFFFFFFB,   32'd0,          64'h00000000_00000000, 2,  1'b0, 0);

        abort_div("annul_busy",  1'b0, 32'd3, 10);
        run_div("divu_200_10",   1'b0, 32'd200,        32'd10,         64'h00000000_00000014, 33, 1'b1, 0);
        abort_div("annul_dzero", 1'b0, 32'd0, 0);
        abort_div("rst_busy",    1'b1, 32'd3, 20);
        run_div("divu_after_rst", 1'b0, 32'd100,       32'd7,          64'h00000002_0000000E, 33, 1'b1, 0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
